// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment driver: scans N_DIGITS digits on clk_10k ticks, with an anode-off
// gap between digits and frame-aligned commit of loaded values. Define SEG7_LZ_BLANK_EN to blank leading zeros.
module seg7_scan #(
    parameter int N_DIGITS       = 4,
    parameter int BLANK_CYC      = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    clk_10k,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    load_ack
);

    localparam int                IDX_W      = $clog2(N_DIGITS);
    localparam logic [1:0]        S_OFF      = 2'd0;
    localparam logic [1:0]        S_BLANK    = 2'd1;
    localparam logic [1:0]        S_ON       = 2'd2;
    localparam logic [9:0]        BLANK_LOAD = (BLANK_CYC > 0) ? 10'(BLANK_CYC - 1) : 10'd0;
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]        SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [N_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic              DP_OFF     = SEG_ACTIVE_LOW;

    logic                    clk_d_reg;
    logic [1:0]              state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [9:0]              cnt_reg, cnt_next;
    logic [4*N_DIGITS-1:0]   disp_val_reg, pend_val_reg;
    logic [N_DIGITS-1:0]     disp_dp_reg, pend_dp_reg;
    logic                    pend_valid_reg;
    logic [6:0]              seg_reg, seg_next;
    logic                    dp_reg, dp_next;
    logic [N_DIGITS-1:0]     an_reg, an_next;
    logic                    load_ack_reg;

    logic                    tick, wrap, commit;
    logic [3:0]              nib [N_DIGITS];
    logic [N_DIGITS-1:0]     onehot;
    logic                    digit_lit;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign tick   = clk_10k & ~clk_d_reg;
    assign wrap   = (state_reg == S_ON) && tick && (idx_reg == IDX_LAST);
    assign commit = wrap && pend_valid_reg;

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign nib[gi]    = disp_val_reg[4*gi +: 4];
            assign onehot[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

`ifdef SEG7_LZ_BLANK_EN
    logic [N_DIGITS-1:0] nz;
    logic [N_DIGITS-1:0] keep;
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lz
            assign nz[gi] = |nib[gi];
            // A digit stays lit if it or any more-significant digit is nonzero; digit 0 always lit.
            if (gi == 0) begin : g_lsd
                assign keep[gi] = 1'b1;
            end else begin : g_upper
                assign keep[gi] = |nz[N_DIGITS-1:gi];
            end
        end
    endgenerate
    assign digit_lit = keep[idx_reg];
`else
    assign digit_lit = 1'b1;
`endif

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_OFF, S_ON: begin
                if (tick) begin
                    if (state_reg == S_ON) begin
                        idx_next = wrap ? '0 : idx_reg + IDX_W'(1);
                    end
                    if (BLANK_CYC == 0) begin
                        state_next = S_ON;
                    end else begin
                        state_next = S_BLANK;
                        cnt_next   = BLANK_LOAD;
                    end
                end
            end
            S_BLANK: begin
                if (cnt_reg == 10'd0) begin
                    state_next = S_ON;
                end else begin
                    cnt_next = cnt_reg - 10'd1;
                end
            end
            default: state_next = S_OFF;
        endcase
    end

    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        dp_next  = DP_OFF;
        if (state_reg == S_ON) begin
            an_next  = AN_ACTIVE_LOW ? ~onehot : onehot;
            dp_next  = SEG_ACTIVE_LOW ? ~disp_dp_reg[idx_reg] : disp_dp_reg[idx_reg];
            if (digit_lit) begin
                seg_next = SEG_ACTIVE_LOW ? ~hex7(nib[idx_reg]) : hex7(nib[idx_reg]);
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            clk_d_reg <= 1'b0;
            state_reg <= S_OFF;
            idx_reg   <= '0;
            cnt_reg   <= 10'd0;
            an_reg    <= AN_OFF;
            seg_reg   <= SEG_OFF;
            dp_reg    <= DP_OFF;
        end else begin
            clk_d_reg <= clk_10k;
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            an_reg    <= an_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
        end
    end

    // A load coinciding with a commit lands in pending after the old pending is displayed.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            disp_val_reg   <= '0;
            disp_dp_reg    <= '0;
            pend_val_reg   <= '0;
            pend_dp_reg    <= '0;
            pend_valid_reg <= 1'b0;
            load_ack_reg   <= 1'b0;
        end else begin
            load_ack_reg <= commit;
            if (commit) begin
                disp_val_reg <= pend_val_reg;
                disp_dp_reg  <= pend_dp_reg;
            end
            if (load) begin
                pend_val_reg   <= value;
                pend_dp_reg    <= dp_in;
                pend_valid_reg <= 1'b1;
            end else if (commit) begin
                pend_valid_reg <= 1'b0;
            end
        end
    end

    assign an       = an_reg;
    assign seg      = seg_reg;
    assign dp       = dp_reg;
    assign load_ack = load_ack_reg;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: table-driven display vectors, hand sequences for load/reset corners,
// and random loads checked every cycle against a tick/time-based reference model.
module tb_seg7_scan;

    localparam int N     = 4;
    localparam int BLANK = 16;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        clk_10k;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        load_ack;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_scan #(
        .N_DIGITS(N), .BLANK_CYC(BLANK), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_in(clk_in), .reset(reset), .clk_10k(clk_10k), .load(load), .value(value),
        .dp_in(dp_in), .seg(seg), .dp(dp), .an(an), .load_ack(load_ack)
    );

    always #5 clk_in = ~clk_in;

    // Scan reference: rising edge every 64 clk_in cycles.
    initial begin
        clk_10k = 1'b0;
        forever begin
            repeat (32) @(negedge clk_in);
            clk_10k = ~clk_10k;
        end
    end

    logic [6:0] seg_tab [16];
    initial begin
        seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
        seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
        seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F; seg_tab[10] = 7'h77; seg_tab[11] = 7'h7C;
        seg_tab[12] = 7'h39; seg_tab[13] = 7'h5E; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t: timed out waiting for DUT", name, $time);
    endtask

    // Reference model: slot k (k-th tick since reset) shows digit (k-1) mod N, dark for the
    // first BLANK+1 samples after its tick; commits happen on ticks that start a new frame.
    int          m_ticks, m_since;
    logic        m_prev10k, m_pv;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_disp_dp, m_pend_dp;
    logic [12:0] m_exp;

    function automatic logic [11:0] digit_view(input int d, input logic [15:0] dv, input logic [3:0] dpv);
        logic [3:0] nibv;
        logic [6:0] s;
        int hi;
        nibv = dv[4*d +: 4];
        s = ~seg_tab[nibv] & 7'h7F;
`ifdef SEG7_LZ_BLANK_EN
        hi = 0;
        for (int i = 0; i < N; i++) if (dv[4*i +: 4] != 4'h0) hi = i;
        if (d > hi) s = 7'h7F;
`else
        hi = 0;
`endif
        return {~(4'b0001 << d), s, ~dpv[d]};
    endfunction

    task automatic model_step();
        logic tk, ack;
        if (reset) begin
            m_ticks = 0; m_since = 0; m_prev10k = 1'b0; m_pv = 1'b0;
            m_disp = '0; m_pend = '0; m_disp_dp = '0; m_pend_dp = '0;
            m_exp = {4'hF, 7'h7F, 1'b1, 1'b0};
            return;
        end
        tk = clk_10k && !m_prev10k;
        m_prev10k = clk_10k;
        ack = 1'b0;
        if (tk) begin
            m_ticks++;
            m_since = 0;
            if (m_ticks > 1 && ((m_ticks - 1) % N) == 0 && m_pv) begin
                m_disp = m_pend; m_disp_dp = m_pend_dp; m_pv = 1'b0; ack = 1'b1;
            end
            m_exp = {m_exp[12:1], ack};
        end else begin
            m_since++;
            if (m_ticks >= 1 && m_since >= BLANK + 1)
                m_exp = {digit_view((m_ticks - 1) % N, m_disp, m_disp_dp), 1'b0};
            else
                m_exp = {4'hF, 7'h7F, 1'b1, 1'b0};
        end
        if (load) begin
            m_pend = value; m_pend_dp = dp_in; m_pv = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            model_step();
            check("cycle{an,seg,dp,ack}", {19'd0, an, seg, dp, load_ack}, {19'd0, m_exp});
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        @(negedge clk_in);
        load = 1'b1; value = v; dp_in = d;
        $display("load value=%h dp=%b at %0t", v, d, $time);
        @(negedge clk_in);
        load = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] target, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk_in); #2;
            if (an == target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_ack(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk_in); #2;
            if (load_ack) begin ok = 1'b1; break; end
        end
    endtask

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpv;
        logic [27:0] segs;   // {d3,d2,d1,d0} expected seg outputs
        logic [3:0]  dps;    // expected dp output per digit
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit ok;
        int acks;
        vec_t v;
        logic [3:0] tgt;

        vecs[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'hABCD, 4'b0101, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1010};
        vecs[3] = '{16'h89EF, 4'b1000, {7'h00, 7'h10, 7'h06, 7'h0E}, 4'b0111};
`ifdef SEG7_LZ_BLANK_EN
        vecs[2] = '{16'h0050, 4'b0000, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
        vecs[4] = '{16'h0000, 4'b0010, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1101};
        vecs[5] = '{16'h0700, 4'b0000, {7'h7F, 7'h78, 7'h40, 7'h40}, 4'b1111};
`else
        vecs[2] = '{16'h0050, 4'b0000, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111};
        vecs[4] = '{16'h0000, 4'b0010, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1101};
        vecs[5] = '{16'h0700, 4'b0000, {7'h40, 7'h78, 7'h40, 7'h40}, 4'b1111};
`endif

        reset = 1'b1; load = 1'b0; value = '0; dp_in = '0;
        repeat (3) @(negedge clk_in);
        #1;
        check("reset_an", {28'd0, an}, 32'hF);
        check("reset_seg", {25'd0, seg}, 32'h7F);
        check("reset_dp", {31'd0, dp}, 32'h1);
        check("reset_ack", {31'd0, load_ack}, 32'h0);
        @(negedge clk_in);
        reset = 1'b0;

        // Table vectors: load, wait for commit, then check each digit slot in scan order.
        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            do_load(v.val, v.dpv);
            wait_ack(1000, ok);
            if (!ok) timeout("vec_ack");
            for (int d = 0; d < N; d++) begin
                tgt = ~(4'b0001 << d);
                wait_an(tgt, 300, ok);
                if (!ok) timeout("vec_scan");
                else begin
                    check("vec_seg", {25'd0, seg}, {25'd0, v.segs[7*d +: 7]});
                    check("vec_dp", {31'd0, dp}, {31'd0, v.dps[d]});
                end
            end
            $display("vector %0d value=%h checked at %0t", k, v.val, $time);
        end

        // Two loads inside one frame: one ack, latest value wins.
        wait_an(4'hE, 300, ok);
        if (!ok) timeout("dbl_sync");
        do_load(16'h1111, 4'b0000);
        repeat (2) @(negedge clk_in);
        do_load(16'h2222, 4'b0000);
        acks = 0;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk_in); #2;
            if (load_ack) acks++;
        end
        check("dbl_ack_count", acks, 1);
        wait_an(4'hE, 300, ok);
        if (!ok) timeout("dbl_digit0");
        else check("dbl_seg0", {25'd0, seg}, 32'h24);

        // Reset while digit 2 is lit: outputs drop immediately, scan restarts at digit 0.
        wait_an(4'hB, 300, ok);
        if (!ok) timeout("rst_sync");
        @(negedge clk_in);
        reset = 1'b1;
        #1;
        check("rst_mid_an", {28'd0, an}, 32'hF);
        check("rst_mid_seg", {25'd0, seg}, 32'h7F);
        check("rst_mid_dp", {31'd0, dp}, 32'h1);
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        $display("reset pulse released at %0t", $time);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_in); #2;
            if (an != 4'hF) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("rst_first_digit");
        else begin
            check("rst_first_an", {28'd0, an}, 32'hE);
            check("rst_first_seg", {25'd0, seg}, 32'h40);
        end

        // Random loads at random phases, sometimes back-to-back.
        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(1, 150)) @(negedge clk_in);
            do_load(16'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) do_load(16'($urandom), 4'($urandom));
        end
        repeat (600) @(negedge clk_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
